// File: rtl/orient_hist_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : orient_hist_acc_if
// Function : Sample-in / result-out bundle of the orientation histogram block.
// Revision : 1.0  initial release
// ============================================================================
interface orient_hist_acc_if #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_dir;
    logic [MAG_W-1:0] in_mag;
    logic             in_last;
    logic             busy;
    logic             out_valid;
    logic [4:0]       out_bin;
    logic [ACC_W-1:0] out_peak;

    modport master (
        output start, in_valid, in_dir, in_mag, in_last,
        input  in_ready, busy, out_valid, out_bin, out_peak
    );

    modport slave (
        input  start, in_valid, in_dir, in_mag, in_last,
        output in_ready, busy, out_valid, out_bin, out_peak
    );
endinterface
`default_nettype wire

// File: rtl/orient_hist_acc.sv
`default_nettype none
// ============================================================================
// Module   : orient_hist_acc
// Function : 32-bin saturating orientation histogram with peak-bin search.
// Revision : 1.0  initial release
// ============================================================================
module orient_hist_acc #(
    parameter int MAG_W   = 8,
    parameter int ACC_W   = 16,
    parameter int WIN_PIX = 256
) (
    input  wire                 clk,
    input  wire                 rst,
    orient_hist_acc_if.slave    bus
);
    localparam int c_CNT_W = $clog2(WIN_PIX) + 1;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_CLEAR = 3'd1;
    localparam logic [2:0] c_S_ACCUM = 3'd2;
    localparam logic [2:0] c_S_SCAN  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [4:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0]   r_bins [0:31];
    logic [ACC_W-1:0]   r_best;
    logic [4:0]         r_best_idx;
    logic [ACC_W-1:0]   r_out_peak;
    logic [4:0]         r_out_bin;

    logic               w_accept;
    logic               w_win_end;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_sat;
    logic [ACC_W-1:0]   w_cur;
    logic [ACC_W-1:0]   w_best;
    logic [4:0]         w_best_idx;

    assign w_accept  = (r_state == c_S_ACCUM) && bus.in_valid;
    assign w_win_end = bus.in_last || (r_cnt == c_CNT_W'(WIN_PIX - 1));

    // One extra carry bit detects overflow so the bin clamps instead of wrapping.
    assign w_sum = {1'b0, r_bins[bus.in_dir]} + {{(ACC_W + 1 - MAG_W){1'b0}}, bus.in_mag};
    assign w_sat = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    assign w_cur = r_bins[r_idx];

    always_comb begin
        w_best     = r_best;
        w_best_idx = r_best_idx;
        // Strict compare keeps the lowest index on ties; index 0 seeds the search.
        if ((r_idx == 5'd0) || (w_cur > r_best)) begin
            w_best     = w_cur;
            w_best_idx = r_idx;
        end
    end

    // Bin storage carries no reset: CLEAR rezeroes it at the start of every window.
    always_ff @(posedge clk) begin
        if (r_state == c_S_CLEAR) begin
            r_bins[r_idx] <= '0;
        end else if (w_accept) begin
            r_bins[bus.in_dir] <= w_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_out_peak <= '0;
            r_out_bin  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_idx <= '0;
                    if (bus.start) begin
                        r_state <= c_S_CLEAR;
                    end
                end
                c_S_CLEAR: begin
                    r_cnt <= '0;
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        r_state <= c_S_ACCUM;
                    end
                end
                c_S_ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_win_end) begin
                            r_state <= c_S_SCAN;
                            r_idx   <= '0;
                        end
                    end
                end
                c_S_SCAN: begin
                    r_best     <= w_best;
                    r_best_idx <= w_best_idx;
                    r_idx      <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        r_out_peak <= w_best;
                        r_out_bin  <= w_best_idx;
                        r_state    <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_S_ACCUM);
    assign bus.busy      = (r_state != c_S_IDLE);
    assign bus.out_valid = (r_state == c_S_DONE);
    assign bus.out_bin   = r_out_bin;
    assign bus.out_peak  = r_out_peak;
endmodule
`default_nettype wire

// File: tb/tb_orient_hist_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_orient_hist_acc
// Function : Directed self-checking bench for orient_hist_acc.
// Revision : 1.0  initial release
// ============================================================================
module tb_orient_hist_acc;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    orient_hist_acc_if #(.MAG_W(8), .ACC_W(16)) ifa ();
    orient_hist_acc_if #(.MAG_W(8), .ACC_W(16)) ifb ();

    orient_hist_acc #(.MAG_W(8), .ACC_W(16), .WIN_PIX(256)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    orient_hist_acc #(.MAG_W(8), .ACC_W(16), .WIN_PIX(512)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
    endtask

    task automatic wait_ready(input int already, input string tag);
        int n;
        n = already;
        while (!ifa.in_ready && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, 32);
    endtask

    task automatic send(input logic [4:0] dir, input logic [7:0] mag, input logic last);
        int n;
        n = 0;
        ifa.in_valid = 1'b1;
        ifa.in_dir   = dir;
        ifa.in_mag   = mag;
        ifa.in_last  = last;
        while (!ifa.in_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
    endtask

    // poke=1 drives start and a sample in the middle of SCAN; both must be ignored.
    task automatic wait_done(input string tag, input logic [4:0] bin, input logic [15:0] peak,
                             input logic poke);
        int n;
        n = 0;
        while (!ifa.out_valid && n < 100) begin
            if (poke && n == 10) begin
                ifa.start    = 1'b1;
                ifa.in_valid = 1'b1;
                ifa.in_dir   = 5'd30;
                ifa.in_mag   = 8'd200;
            end else begin
                ifa.start    = 1'b0;
                ifa.in_valid = 1'b0;
            end
            tick();
            n++;
        end
        ifa.start    = 1'b0;
        ifa.in_valid = 1'b0;
        check({tag, "_lat"}, n, 32);
        check({tag, "_bin"}, ifa.out_bin, bin);
        check({tag, "_peak"}, ifa.out_peak, peak);
        tick();
        check({tag, "_pulse"}, ifa.out_valid, 0);
        check({tag, "_idle"}, ifa.busy, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_dir = '0; ifa.in_mag = '0; ifa.in_last = 1'b0;
        ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_dir = '0; ifb.in_mag = '0; ifb.in_last = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_ready", ifa.in_ready, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_valid", ifa.out_valid, 0);
        check("rst_bin", ifa.out_bin, 0);
        check("rst_peak", ifa.out_peak, 0);

        // Samples offered in IDLE are refused.
        ifa.in_valid = 1'b1; ifa.in_dir = 5'd4; ifa.in_mag = 8'd99;
        tick();
        check("idle_ready", ifa.in_ready, 0);
        check("idle_busy", ifa.busy, 0);
        ifa.in_valid = 1'b0;

        // Basic accumulation.
        do_start();
        check("start_busy", ifa.busy, 1);
        wait_ready(0, "t1_clear_lat");
        send(5'd5, 8'd10, 1'b0);
        send(5'd5, 8'd20, 1'b0);
        send(5'd31, 8'd25, 1'b1);
        check("t1_scan_ready", ifa.in_ready, 0);
        wait_done("t1", 5'd5, 16'd30, 1'b0);

        // Tie goes to the lower index, then a fresh window proves CLEAR.
        do_start();
        wait_ready(0, "t2_clear_lat");
        send(5'd7, 8'd40, 1'b0);
        send(5'd3, 8'd40, 1'b1);
        wait_done("t2a", 5'd3, 16'd40, 1'b0);
        do_start();
        wait_ready(0, "t2b_clear_lat");
        send(5'd9, 8'd1, 1'b1);
        wait_done("t2b", 5'd9, 16'd1, 1'b0);

        // Count-forced window end, then a 257th offer while scanning.
        do_start();
        wait_ready(0, "t4_clear_lat");
        for (int i = 0; i < 256; i++) send(5'd0, 8'd1, 1'b0);
        ifa.in_valid = 1'b1;
        check("t4_257_ready", ifa.in_ready, 0);
        check("t4_busy", ifa.busy, 1);
        ifa.in_valid = 1'b0;
        wait_done("t4", 5'd0, 16'h0100, 1'b0);

        // Reset during ACCUM discards the window.
        do_start();
        wait_ready(0, "t5_clear_lat");
        send(5'd20, 8'd250, 1'b0);
        send(5'd20, 8'd250, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_busy", ifa.busy, 0);
        check("t5_rst_valid", ifa.out_valid, 0);
        check("t5_rst_peak", ifa.out_peak, 0);
        do_start();
        wait_ready(0, "t5_clear_lat2");
        send(5'd2, 8'd3, 1'b1);
        wait_done("t5", 5'd2, 16'd3, 1'b0);

        // Stray start/sample during CLEAR and SCAN.
        do_start();
        for (int i = 0; i < 5; i++) tick();
        ifa.start = 1'b1; ifa.in_valid = 1'b1; ifa.in_dir = 5'd4; ifa.in_mag = 8'd99; ifa.in_last = 1'b1;
        tick();
        ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
        wait_ready(6, "t6_clear_lat");
        send(5'd6, 8'd7, 1'b1);
        wait_done("t6", 5'd6, 16'd7, 1'b1);
        tick();
        check("t6_no_restart", ifa.busy, 0);

        // Saturation on the 512-sample instance.
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        n = 0;
        while (!ifb.in_ready && n < 100) begin tick(); n++; end
        check("t3_clear_lat", n, 32);
        ifb.in_valid = 1'b1; ifb.in_dir = 5'd12; ifb.in_mag = 8'd255;
        for (int i = 0; i < 300; i++) begin
            ifb.in_last = (i == 299);
            n = 0;
            while (!ifb.in_ready && n < 100) begin tick(); n++; end
            tick();
        end
        ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
        n = 0;
        while (!ifb.out_valid && n < 100) begin tick(); n++; end
        check("t3_lat", n, 32);
        check("t3_bin", ifb.out_bin, 12);
        check("t3_peak", ifb.out_peak, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
